// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the MEM stage: one access per handshake, LATENCY wait cycles, lane-shifted loads.
// Response LATENCY+1 cycles after acceptance; req_ready only in IDLE, stall_req held until the response cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wea,
  input  logic [2:0]  req_len,
  input  logic        req_signed_ext,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_req
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, commit;
  logic          len_bad, req_err;
  logic [3:0]    wea_exp;

  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wea_q;
  logic [2:0]    len_q;
  logic          sext_q, err_q;

  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_wea;
  logic [2:0]    c_len;
  logic          c_sext, c_err;

  logic [AW-1:0] c_idx;
  logic [31:0]   rd_word, rd_shift, ld_data, st_data;
  logic [3:0]    st_be;
  logic          unused_addr_hi;

  logic [31:0]   mem [DEPTH_WORDS];

  assign unused_addr_hi = ^req_addr[31:AW+2];

  always_comb begin
    len_bad = 1'b1;
    wea_exp = 4'b0000;
    case (req_len)
      3'b001: begin len_bad = 1'b0;          wea_exp = 4'b0001; end
      3'b010: begin len_bad = req_addr[0];   wea_exp = 4'b0011; end
      3'b100: begin len_bad = |req_addr[1:0]; wea_exp = 4'b1111; end
      default: ;
    endcase
    req_err = len_bad | ((req_wea != 4'b0000) & (req_wea != wea_exp));
  end

  // With LATENCY=0 the commit edge is the acceptance edge, so use live inputs in IDLE.
  assign c_addr  = (state_q == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata        : wdata_q;
  assign c_wea   = (state_q == IDLE) ? req_wea          : wea_q;
  assign c_len   = (state_q == IDLE) ? req_len          : len_q;
  assign c_sext  = (state_q == IDLE) ? req_signed_ext   : sext_q;
  assign c_err   = (state_q == IDLE) ? req_err          : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign stall_req = !rst & ((state_q == WAIT) | ((state_q == IDLE) & req_valid));

  assign c_idx    = c_addr[AW+1:2];
  assign st_be    = c_wea << c_addr[1:0];
  assign rd_word  = mem[c_idx];
  assign rd_shift = rd_word >> {c_addr[1:0], 3'b000};

  always_comb begin
    case (c_len)
      3'b001:  st_data = {4{c_wdata[7:0]}};
      3'b010:  st_data = {2{c_wdata[15:0]}};
      default: st_data = c_wdata;
    endcase
  end

  always_comb begin
    case (c_len)
      3'b001:  ld_data = c_sext ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                : {24'b0, rd_shift[7:0]};
      3'b010:  ld_data = c_sext ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                : {16'b0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  // Reset in the commit cycle drops the store along with the access.
  always_ff @(posedge clk) begin
    if (!rst && commit && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[c_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_valid <= commit;
      resp_err   <= commit & c_err;
      resp_rdata <= (commit && !c_err && (c_wea == 4'b0000)) ? ld_data : 32'b0;
      if (accept) begin
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        wea_q   <= req_wea;
        len_q   <= req_len;
        sext_q  <= req_signed_ext;
        err_q   <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wea;
  logic [2:0]  req_len;
  logic        req_signed_ext;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wea(req_wea),
    .req_len(req_len), .req_signed_ext(req_signed_ext),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall_req(stall_req)
  );

  // Memory seen as 4096 bytes; an access touches `size` consecutive bytes.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                                input logic [2:0] ln, input logic se,
                                output logic [31:0] rd, output logic er);
    int size, word, off;
    logic [31:0] w;
    logic [63:0] v;
    size = (ln == 3'd1) ? 1 : (ln == 3'd2) ? 2 : (ln == 3'd4) ? 4 : 0;
    rd = 32'b0;
    if (size == 0) er = 1'b1;
    else er = ((a % size) != 0) || (we != 4'd0 && we != 4'((1 << size) - 1));
    if (er) return;
    off  = int'(a % 4);
    word = int'(a % 4096) / 4;
    w = mdl.exists(word) ? mdl[word] : 32'hx;
    if (we != 4'd0) begin
      for (int i = 0; i < size; i++) w[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
      mdl[word] = w;
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v[i * 8 +: 8] = w[(off + i) * 8 +: 8];
      if (se && size < 4 && v[size * 8 - 1]) v = v - (64'd1 << (size * 8));
      rd = v[31:0];
    end
  endfunction

  task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                     input logic [2:0] ln, input logic se,
                     output logic [31:0] rd, output logic er,
                     output logic [31:0] erd, output logic eer,
                     output int lat, output int stl, output logic rdy,
                     output logic resp_stall, output logic resp_rdy, output logic after_vld);
    model(a, wd, we, ln, se, erd, eer);
    @(negedge clk);
    req_addr = a; req_wdata = wd; req_wea = we; req_len = ln; req_signed_ext = se;
    req_valid = 1'b1;
    #1;
    rdy = req_ready;
    stl = int'(stall_req);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_wea = 4'($urandom);
    req_len = 3'($urandom); req_signed_ext = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 50) begin
      stl += int'(stall_req);
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    resp_stall = stall_req; resp_rdy = req_ready;
    @(posedge clk); #1;
    after_vld = resp_valid;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h100; req_wdata = 32'h5555_5555;
    req_wea = 4'hF; req_len = 3'd4; req_signed_ext = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_req); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_resp got %h/%b exp 0/0", resp_rdata, resp_err); end
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_accept got %0d responses exp 0", seen); end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd; logic er, eer, rdy, rs, rr, av; int lat, stl;
    run(32'h100, 32'hDEADBEEF, 4'hF, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_ready got %b exp 1", rdy); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", lat); end
    checks++; if (stl != 3) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 3", stl); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL sw_resp_stall got %b exp 0", rs); end
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL sw_resp_ready got %b exp 0", rr); end
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL sw_pulse got %b exp 0", av); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got %h/%b exp 0/0", rd, er); end
    run(32'h100, 32'h0, 4'h0, 3'd4, 1'b1, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
    checks++; if (lat != 3 || stl != 3) begin errors++; $display("FAIL lw_timing got lat %0d stall %0d exp 3/3", lat, stl); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd, erd; logic er, eer, rdy, rs, rr, av; int lat, stl;
    run(32'h103, 32'h80, 4'h1, 3'd1, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", er); end
    run(32'h103, 32'h0, 4'h0, 3'd1, 1'b1, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", rd); end
    run(32'h103, 32'h0, 4'h0, 3'd1, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", rd); end
    run(32'h100, 32'h0, 4'h0, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb got %h exp 80adbeef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd, erd; logic er, eer, rdy, rs, rr, av; int lat, stl;
    run(32'h202, 32'h8001, 4'h3, 3'd2, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_err got %b exp 0", er); end
    run(32'h202, 32'h0, 4'h0, 3'd2, 1'b1, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", rd); end
    run(32'h202, 32'h0, 4'h0, 3'd2, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer, rdy, rs, rr, av; int lat, stl;
    run(32'h201, 32'h0, 4'h0, 3'd2, 1'b1, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misalign got %h/%b exp 0/1", rd, er); end
    checks++; if (lat != 3) begin errors++; $display("FAIL err_latency got %0d exp 3", lat); end
    run(32'h102, 32'h12345678, 4'hF, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_misalign got %h/%b exp 0/1", rd, er); end
    run(32'h100, 32'hAAAAAAAA, 4'hF, 3'd1, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL wea_mismatch got %b exp 1", er); end
    run(32'h100, 32'h0, 4'h0, 3'd3, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL len_011 got %h/%b exp 0/1", rd, er); end
    run(32'h100, 32'h0, 4'h0, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h80ADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_unchanged got %h/%b exp 80adbeef/0", rd, er); end
  endtask

  task automatic test_wrap_abort();
    logic [31:0] rd, erd; logic er, eer, rdy, rs, rr, av; int lat, stl, seen;
    run(32'h1000, 32'h11111111, 4'hF, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    run(32'h0, 32'h0, 4'h0, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL wrap_lw got %h exp 11111111", rd); end
    @(negedge clk);
    req_addr = 32'h0; req_wdata = 32'h22222222; req_wea = 4'hF; req_len = 3'd4; req_signed_ext = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_resp got %0d responses exp 0", seen); end
    run(32'h0, 32'h0, 4'h0, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_dropped got %h exp 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd; logic eer;
    logic [8:0] vmask;
    logic       stall_in_resp;
    logic [31:0] data3, data7;
    model(32'h100, 32'h0, 4'h0, 3'd4, 1'b0, erd, eer);
    @(negedge clk);
    req_addr = 32'h100; req_wdata = 32'h0; req_wea = 4'h0; req_len = 3'd4; req_signed_ext = 1'b0;
    req_valid = 1'b1;
    vmask = '0; stall_in_resp = 1'b1; data3 = 32'h0; data7 = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      vmask[k] = resp_valid;
      if (k == 3) begin stall_in_resp = stall_req; data3 = resp_rdata; end
      if (k == 7) data7 = resp_rdata;
      if (k == 5) req_valid = 1'b0;
    end
    checks++; if (vmask !== 9'b0_1000_1000) begin errors++; $display("FAIL b2b_pulses got %b exp 010001000", vmask); end
    checks++; if (stall_in_resp !== 1'b0) begin errors++; $display("FAIL b2b_resp_stall got %b exp 0", stall_in_resp); end
    checks++; if (data3 !== erd || data7 !== erd) begin errors++; $display("FAIL b2b_data got %h %h exp %h", data3, data7, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, rdy, rs, rr, av, se; int lat, stl, r;
    logic [2:0] ln; logic [3:0] we;
    for (int i = 0; i < 16; i++) begin
      run(32'(i * 4), $urandom, 4'hF, 3'd4, 1'b0, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
      checks++; if (er !== eer) begin errors++; $display("FAIL rnd_init_err got %b exp %b", er, eer); end
    end
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      r = $urandom_range(0, 9);
      ln = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : 3'($urandom);
      we = 4'h0;
      if ($urandom_range(0, 1) == 1) we = (ln == 3'd1) ? 4'h1 : (ln == 3'd2) ? 4'h3 : 4'hF;
      if ($urandom_range(0, 7) == 0) we = 4'($urandom);
      wd = $urandom; se = 1'($urandom);
      run(a, wd, we, ln, se, rd, er, erd, eer, lat, stl, rdy, rs, rr, av);
      checks++; if (er !== eer) begin errors++; $display("FAIL rnd_err op%0d a=%h len=%b wea=%b got %b exp %b", i, a, ln, we, er, eer); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_data op%0d a=%h len=%b se=%b got %h exp %h", i, a, ln, se, rd, erd); end
      checks++; if (lat != 3) begin errors++; $display("FAIL rnd_latency op%0d got %0d exp 3", i, lat); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_wea = '0; req_len = '0; req_signed_ext = 1'b0;
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_errors();
    test_wrap_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
